// File: rtl/flex_deser_pkg.sv
// Shared helpers for the flexible serial-to-parallel deserializer.
package flex_deser_pkg;

    // Width of a count that must represent 0..w inclusive.
    function automatic int mod_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Buffer position of the k-th received bit of a word (k = 0 is the first bit).
    function automatic int pos(input int k, input bit msb_first, input int w);
        if (msb_first) begin
            return w - 1 - k;
        end else begin
            return k;
        end
    endfunction

endpackage

// File: rtl/flex_deserializer_if.sv
// Serial input handshake and parallel output handshake of the deserializer.
interface flex_deserializer_if
    import flex_deser_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int MOD_WIDTH      = mod_width(DATA_BUS_WIDTH)
);
    logic                      data_i;
    logic                      data_val_i;
    logic                      data_last_i;
    logic                      data_ready_o;
    logic [DATA_BUS_WIDTH-1:0] deser_data_o;
    logic [MOD_WIDTH-1:0]      deser_data_mod_o;
    logic                      deser_data_val_o;
    logic                      deser_data_ready_i;

    // Deserializer side.
    modport slave (
        input  data_i, data_val_i, data_last_i, deser_data_ready_i,
        output data_ready_o, deser_data_o, deser_data_mod_o, deser_data_val_o
    );

    // Source / consumer side.
    modport master (
        output data_i, data_val_i, data_last_i, deser_data_ready_i,
        input  data_ready_o, deser_data_o, deser_data_mod_o, deser_data_val_o
    );
endinterface

// File: rtl/deser_out_reg.sv
// Valid/ready output holding register; also produces the upstream ready.
module deser_out_reg #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int MOD_WIDTH      = 5
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      load_i,
    input  logic [DATA_BUS_WIDTH-1:0] word_i,
    input  logic [MOD_WIDTH-1:0]      mod_i,
    input  logic                      out_ready_i,
    output logic                      in_ready_o,
    output logic [DATA_BUS_WIDTH-1:0] out_data_o,
    output logic [MOD_WIDTH-1:0]      out_mod_o,
    output logic                      out_val_o
);
    logic                      val_q;
    logic [DATA_BUS_WIDTH-1:0] data_q;
    logic [MOD_WIDTH-1:0]      mod_q;

    // A new word may enter when the register is empty or being drained this cycle.
    assign in_ready_o = !val_q || out_ready_i;

    // Load a completed word, release on handshake, otherwise hold the word stable.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            val_q  <= 1'b0;
            data_q <= {DATA_BUS_WIDTH{1'b0}};
            mod_q  <= {MOD_WIDTH{1'b0}};
        end else if (load_i) begin
            val_q  <= 1'b1;
            data_q <= word_i;
            mod_q  <= mod_i;
        end else if (out_ready_i) begin
            val_q  <= 1'b0;
        end else begin
            val_q  <= val_q;
            data_q <= data_q;
            mod_q  <= mod_q;
        end
    end

    assign out_val_o  = val_q;
    assign out_data_o = data_q;
    assign out_mod_o  = mod_q;
endmodule

// File: rtl/flex_deserializer.sv
// Serial bit collector with selectable bit order and early word termination.
module flex_deserializer
    import flex_deser_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int MSB_FIRST      = 1,
    parameter int MOD_WIDTH      = mod_width(DATA_BUS_WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    flex_deserializer_if.slave   bus_if
);
    logic [MOD_WIDTH-1:0]      cnt_q;
    logic [MOD_WIDTH-1:0]      cnt_d;
    logic [DATA_BUS_WIDTH-1:0] buf_q;
    logic [DATA_BUS_WIDTH-1:0] buf_d;
    logic [DATA_BUS_WIDTH-1:0] word_s;
    logic [MOD_WIDTH-1:0]      mod_s;
    logic                      in_ready_s;
    logic                      accept_s;
    logic                      is_final_s;
    logic                      done_s;
    int                        bit_pos_s;

    assign accept_s   = bus_if.data_val_i && in_ready_s;
    assign is_final_s = (cnt_q == MOD_WIDTH'(DATA_BUS_WIDTH - 1)) || bus_if.data_last_i;
    assign done_s     = accept_s && is_final_s;
    assign mod_s      = cnt_q + MOD_WIDTH'(1);

    // Buffer slot that the bit currently on data_i would occupy.
    always_comb begin
        bit_pos_s = pos(int'(cnt_q), (MSB_FIRST != 0), DATA_BUS_WIDTH);
    end

    // Current buffer with the incoming bit merged in, so the completing bit is not lost.
    always_comb begin
        word_s = buf_q;
        for (int i = 0; i < DATA_BUS_WIDTH; i++) begin
            word_s[i] = buf_q[i] | (bus_if.data_i & (i == bit_pos_s));
        end
    end

    // Advance on each accepted bit; a completing bit restarts a fresh empty word.
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (accept_s) begin
            if (is_final_s) begin
                cnt_d = {MOD_WIDTH{1'b0}};
                buf_d = {DATA_BUS_WIDTH{1'b0}};
            end else begin
                cnt_d = mod_s;
                buf_d = word_s;
            end
        end else begin
            cnt_d = cnt_q;
            buf_d = buf_q;
        end
    end

    // Collector state; reset discards any partially received word.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= {MOD_WIDTH{1'b0}};
            buf_q <= {DATA_BUS_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    deser_out_reg #(
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
        .MOD_WIDTH      (MOD_WIDTH)
    ) u_out_reg (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .load_i      (done_s),
        .word_i      (word_s),
        .mod_i       (mod_s),
        .out_ready_i (bus_if.deser_data_ready_i),
        .in_ready_o  (in_ready_s),
        .out_data_o  (bus_if.deser_data_o),
        .out_mod_o   (bus_if.deser_data_mod_o),
        .out_val_o   (bus_if.deser_data_val_o)
    );

    assign bus_if.data_ready_o = in_ready_s;
endmodule
